// File: rtl/sfp_pkg.sv
// Shared definitions for the SFP telemetry framer: FSM states, framing
// constants, header field positions and the payload beat count helper.
package sfp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_TRL
    } state_e;

    localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hA55A;
    localparam logic [15:0] TRAILER_TAG       = 16'hE0F0;

    // Least significant bit of each header field
    localparam int HDR_SYNC_LSB  = 48;
    localparam int HDR_NCH_LSB   = 40;
    localparam int HDR_ID_LSB    = 32;
    localparam int HDR_SEQ_LSB   = 16;
    localparam int HDR_BEATS_LSB = 0;

    // Two 32-bit channels share one 64-bit beat; an odd count leaves a zero pad
    function automatic int payload_beats(input int numCh);
        return (numCh + 1) / 2;
    endfunction

endpackage

// File: rtl/sfp_auto_trig.sv
// Periodic snapshot tick generator. The counter only runs while enabled and
// sits at zero otherwise, so the first tick after enabling always lands a
// full period later. A period of zero builds no logic at all.
module sfp_auto_trig #(
    parameter int AUTO_PERIOD = 0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_tick
);

    generate
        if (AUTO_PERIOD == 0) begin : g_off
            logic unusedInputs;
            assign unusedInputs = &{1'b0, i_clk, i_rst, i_en};
            assign o_tick = 1'b0;
        end else begin : g_on
            localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
            localparam logic [CW-1:0] TOP = CW'(AUTO_PERIOD - 1);

            logic [CW-1:0] count_q;

            // Free-running modulo-AUTO_PERIOD count, held at zero while disabled
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    count_q <= '0;
                end else if (!i_en) begin
                    count_q <= '0;
                end else if (count_q == TOP) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end

            assign o_tick = i_en & (count_q == TOP);
        end
    endgenerate

endmodule

// File: rtl/sfp_telemetry_framer.sv
// Snapshots NUM_CH monitor channels on a trigger and streams them out as one
// framed AXI-Stream packet: header, packed payload, checksum trailer.
// All stream outputs come straight from registers; tvalid is the busy flag.
module sfp_telemetry_framer
    import sfp_pkg::*;
#(
    parameter int          NUM_CH      = 9,
    parameter int          AUTO_PERIOD = 0,
    parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [1:0]            i_sfp_id,
    input  logic                  i_trig,
    input  logic [NUM_CH*32-1:0]  i_ch_data,
    output logic [63:0]           m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  o_busy,
    output logic [15:0]           o_seq,
    output logic [15:0]           o_drop_cnt
);

    localparam int         P        = payload_beats(NUM_CH);
    localparam logic [7:0] LAST_IDX = 8'(P - 1);

    state_e          state_q;
    logic [P*64-1:0] snap_q;
    logic [31:0]     accSum_q;
    logic [7:0]      beatIdx_q;
    logic [15:0]     seq_q;
    logic [15:0]     drop_q;
    logic [63:0]     tdata_q;
    logic            tlast_q;

    logic            autoTick;
    logic            trig;
    logic [P*64-1:0] chPadded;
    logic [63:0]     header_d;
    logic [63:0]     nextBeat_d;
    logic [31:0]     accSum_d;

    sfp_auto_trig #(
        .AUTO_PERIOD (AUTO_PERIOD)
    ) u_auto_trig (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (i_en),
        .o_tick (autoTick)
    );

    assign trig = i_en & (i_trig | autoTick);

    // Channel data widened to whole beats so an odd channel count pads with zero
    always_comb begin
        chPadded = '0;
        chPadded[NUM_CH*32-1:0] = i_ch_data;
    end

    // Header assembled from live ID and current sequence at the moment of capture
    always_comb begin
        header_d = '0;
        header_d[HDR_SYNC_LSB  +: 16] = SYNC_WORD;
        header_d[HDR_NCH_LSB   +: 8]  = 8'(NUM_CH);
        header_d[HDR_ID_LSB    +: 2]  = i_sfp_id;
        header_d[HDR_SEQ_LSB   +: 16] = seq_q;
        header_d[HDR_BEATS_LSB +: 16] = 16'(P);
    end

    // Selects the payload beat that follows the one currently on the bus
    always_comb begin
        nextBeat_d = '0;
        for (int j = 0; j < P; j++) begin
            if (int'(beatIdx_q) + 1 == j) begin
                nextBeat_d = snap_q[j*64 +: 64];
            end
        end
    end

    // The beat on the bus is the one being accepted, so it feeds the checksum
    assign accSum_d = accSum_q + tdata_q[31:0] + tdata_q[63:32];

    // Frame sequencer; loads the next beat into the output register on each handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            snap_q    <= '0;
            accSum_q  <= '0;
            beatIdx_q <= '0;
            seq_q     <= '0;
            tdata_q   <= '0;
            tlast_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        snap_q    <= chPadded;
                        accSum_q  <= '0;
                        beatIdx_q <= '0;
                        tdata_q   <= header_d;
                        tlast_q   <= 1'b0;
                        state_q   <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (m_axis_tready) begin
                        tdata_q <= snap_q[63:0];
                        state_q <= ST_PAY;
                    end
                end
                ST_PAY: begin
                    if (m_axis_tready) begin
                        accSum_q <= accSum_d;
                        if (beatIdx_q == LAST_IDX) begin
                            tdata_q <= {accSum_d, seq_q, TRAILER_TAG};
                            tlast_q <= 1'b1;
                            state_q <= ST_TRL;
                        end else begin
                            beatIdx_q <= beatIdx_q + 1'b1;
                            tdata_q   <= nextBeat_d;
                        end
                    end
                end
                ST_TRL: begin
                    if (m_axis_tready) begin
                        seq_q   <= seq_q + 1'b1;
                        tdata_q <= '0;
                        tlast_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Counts triggers that arrive while a frame is in flight, saturating at all-ones
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drop_q <= '0;
        end else if (trig && (state_q != ST_IDLE) && (drop_q != 16'hFFFF)) begin
            drop_q <= drop_q + 1'b1;
        end
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign m_axis_tvalid = o_busy;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign o_seq         = seq_q;
    assign o_drop_cnt    = drop_q;

endmodule

// File: tb/tb_sfp_telemetry_framer.sv
// Bench for the SFP telemetry framer. Three instances cover the nine-channel
// default, a periodic-trigger build and a single-channel build. Expected
// frames are generated by an independent model and queued when triggered.
module tb_sfp_telemetry_framer;

    typedef logic [64:0] beat_t;
    typedef beat_t beatQ_t[$];

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    always #5 clk = ~clk;

    // Cycle index, used to time the periodic frames
    always @(posedge clk) cyc <= cyc + 1;

    logic         en9, trig9, ready9;
    logic [1:0]   id9;
    logic [287:0] ch9;
    logic [63:0]  tdata9;
    logic         valid9, last9, busy9;
    logic [15:0]  seq9, drop9;

    logic         enA, trigA, readyA;
    logic [1:0]   idA;
    logic [287:0] chA;
    logic [63:0]  tdataA;
    logic         validA, lastA, busyA;
    logic [15:0]  seqA, dropA;

    logic         en1, trig1, ready1;
    logic [1:0]   id1;
    logic [31:0]  ch1;
    logic [63:0]  tdata1;
    logic         valid1, last1, busy1;
    logic [15:0]  seq1, drop1;

    int testsRun    = 0;
    int testsFailed = 0;

    beatQ_t sb9, sbA, sb1;
    beat_t  rx9[$], rx1[$];
    int     startA[$];

    sfp_telemetry_framer #(.NUM_CH(9), .AUTO_PERIOD(0)) dut9 (
        .i_clk(clk), .i_rst(rst), .i_en(en9), .i_sfp_id(id9), .i_trig(trig9),
        .i_ch_data(ch9), .m_axis_tdata(tdata9), .m_axis_tvalid(valid9),
        .m_axis_tready(ready9), .m_axis_tlast(last9), .o_busy(busy9),
        .o_seq(seq9), .o_drop_cnt(drop9)
    );

    sfp_telemetry_framer #(.NUM_CH(9), .AUTO_PERIOD(16)) dutA (
        .i_clk(clk), .i_rst(rst), .i_en(enA), .i_sfp_id(idA), .i_trig(trigA),
        .i_ch_data(chA), .m_axis_tdata(tdataA), .m_axis_tvalid(validA),
        .m_axis_tready(readyA), .m_axis_tlast(lastA), .o_busy(busyA),
        .o_seq(seqA), .o_drop_cnt(dropA)
    );

    sfp_telemetry_framer #(.NUM_CH(1), .AUTO_PERIOD(0)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_en(en1), .i_sfp_id(id1), .i_trig(trig1),
        .i_ch_data(ch1), .m_axis_tdata(tdata1), .m_axis_tvalid(valid1),
        .m_axis_tready(ready1), .m_axis_tlast(last1), .o_busy(busy1),
        .o_seq(seq1), .o_drop_cnt(drop1)
    );

    task automatic checkOutput(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic reportExtra(input string tag, input logic [64:0] obs);
        testsRun++;
        testsFailed++;
        $error("[TB] FAIL %s: observed %h expected no beat", tag, obs);
    endtask

    // Reference frame: header, packed payload with zero pad, summed trailer
    function automatic beatQ_t makeFrame(input logic [287:0] chv, input int nch,
                                         input logic [1:0] id, input logic [15:0] seq);
        beatQ_t      fr;
        int          p;
        logic [31:0] sum;
        logic [31:0] lo;
        logic [31:0] hi;
        p   = (nch + 1) / 2;
        sum = 32'h0;
        fr.push_back({1'b0, 16'hA55A, 8'(nch), 6'b0, id, seq, 16'(p)});
        for (int j = 0; j < p; j++) begin
            lo  = chv[2*j*32 +: 32];
            hi  = (2*j + 1 < nch) ? chv[(2*j+1)*32 +: 32] : 32'h0;
            sum = sum + lo + hi;
            fr.push_back({1'b0, hi, lo});
        end
        fr.push_back({1'b1, sum, seq, 16'hE0F0});
        return fr;
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return sb9.size();
            1:       return sbA.size();
            default: return sb1.size();
        endcase
    endfunction

    // Queue the expected frame, then pulse the trigger for one cycle
    task automatic applyStimulus(input int which, input logic [15:0] seq);
        beatQ_t fr;
        if (which == 0) begin
            fr = makeFrame(ch9, 9, id9, seq);
            foreach (fr[i]) sb9.push_back(fr[i]);
            trig9 = 1'b1;
        end else begin
            fr = makeFrame({256'b0, ch1}, 1, id1, seq);
            foreach (fr[i]) sb1.push_back(fr[i]);
            trig1 = 1'b1;
        end
        @(posedge clk);
        #1;
        trig9 = 1'b0;
        trig1 = 1'b0;
    endtask

    task automatic waitDrain(input int which, input int budget);
        int n = 0;
        while (qsize(which) != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        checkOutput("drain", 65'(qsize(which)), 65'd0);
    endtask

    logic        stall9 = 1'b0, stallA = 1'b0, stall1 = 1'b0, prevValidA = 1'b0;
    logic [63:0] held9, heldA, held1;

    // Scoreboard for the nine-channel instance, plus hold check on stalls
    always @(negedge clk) begin
        if (rst) begin
            stall9 <= 1'b0;
        end else begin
            if (valid9) begin
                if (stall9) checkOutput("hold9", 65'(tdata9), 65'(held9));
                if (ready9) begin
                    if (sb9.size() == 0) reportExtra("extra9", {last9, tdata9});
                    else begin
                        checkOutput("beat9", {last9, tdata9}, sb9.pop_front());
                        rx9.push_back({last9, tdata9});
                    end
                end
            end
            stall9 <= valid9 & ~ready9;
            held9  <= tdata9;
        end
    end

    // Scoreboard for the periodic instance, also logging frame start cycles
    always @(negedge clk) begin
        if (rst) begin
            stallA     <= 1'b0;
            prevValidA <= 1'b0;
        end else begin
            if (validA) begin
                if (!prevValidA) startA.push_back(cyc);
                if (stallA) checkOutput("holdA", 65'(tdataA), 65'(heldA));
                if (readyA) begin
                    if (sbA.size() == 0) reportExtra("extraA", {lastA, tdataA});
                    else checkOutput("beatA", {lastA, tdataA}, sbA.pop_front());
                end
            end
            stallA     <= validA & ~readyA;
            prevValidA <= validA;
            heldA      <= tdataA;
        end
    end

    // Scoreboard for the single-channel instance
    always @(negedge clk) begin
        if (rst) begin
            stall1 <= 1'b0;
        end else begin
            if (valid1) begin
                if (stall1) checkOutput("hold1", 65'(tdata1), 65'(held1));
                if (ready1) begin
                    if (sb1.size() == 0) reportExtra("extra1", {last1, tdata1});
                    else begin
                        checkOutput("beat1", {last1, tdata1}, sb1.pop_front());
                        rx1.push_back({last1, tdata1});
                    end
                end
            end
            stall1 <= valid1 & ~ready1;
            held1  <= tdata1;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        beatQ_t     fr;
        int         base;

        pat = 4'b1001;
        rst = 1'b1;
        en9 = 1'b1; trig9 = 1'b0; ready9 = 1'b1; id9 = 2'd2;
        enA = 1'b0; trigA = 1'b0; readyA = 1'b1; idA = 2'd1;
        en1 = 1'b1; trig1 = 1'b0; ready1 = 1'b1; id1 = 2'd3;
        for (int k = 0; k < 9; k++) begin
            ch9[k*32 +: 32] = 32'h1000_0000 + 32'(k);
            chA[k*32 +: 32] = 32'h2000_0000 + 32'(k * 3);
        end
        ch1 = 32'hDEAD_BEEF;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstValid", 65'(valid9), 65'd0);
        checkOutput("rstLast",  65'(last9),  65'd0);
        checkOutput("rstData",  65'(tdata9), 65'd0);
        checkOutput("rstBusy",  65'(busy9),  65'd0);
        checkOutput("rstSeq",   65'(seq9),   65'd0);
        checkOutput("rstDrop",  65'(drop9),  65'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single frame, tready held high
        applyStimulus(0, 16'd0);
        checkOutput("latency", 65'(valid9), 65'd1);
        checkOutput("hdrFirst", 65'(tdata9), 65'h0_A55A_0902_0000_0005);
        waitDrain(0, 50);
        checkOutput("seqAfter", 65'(seq9), 65'd1);
        checkOutput("idleAfter", 65'(busy9), 65'd0);
        checkOutput("rxCount", 65'(rx9.size()), 65'd7);
        checkOutput("hdr", rx9[0], 65'h0_A55A_0902_0000_0005);
        checkOutput("pay0", rx9[1], 65'h0_1000_0001_1000_0000);
        checkOutput("pay4", rx9[5], 65'h0_0000_0000_1000_0008);
        checkOutput("trailer", rx9[6], {1'b1, 32'h9000_0024, 16'h0001 - 16'h0001, 16'hE0F0});

        // Same frame with back-pressure
        rx9.delete();
        applyStimulus(0, 16'd1);
        for (int n = 0; n < 200 && sb9.size() != 0; n++) begin
            ready9 = (n < 4) ? pat[n] : 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        ready9 = 1'b1;
        checkOutput("stallDrain", 65'(sb9.size()), 65'd0);
        checkOutput("stallCount", 65'(rx9.size()), 65'd7);
        checkOutput("stallSeq", 65'(seq9), 65'd2);

        // Drop counting and snapshot isolation
        applyStimulus(0, 16'd2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        ch9 = ~ch9;
        @(posedge clk); #1;
        trig9 = 1'b1;
        @(posedge clk); #1;
        trig9 = 1'b0;
        waitDrain(0, 50);
        checkOutput("drop", 65'(drop9), 65'd1);
        checkOutput("dropSeq", 65'(seq9), 65'd3);
        ch9 = ~ch9;

        // Reset in the middle of a frame
        applyStimulus(0, 16'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkOutput("abortValid", 65'(valid9), 65'd0);
        checkOutput("abortLast",  65'(last9),  65'd0);
        checkOutput("abortData",  65'(tdata9), 65'd0);
        checkOutput("abortSeq",   65'(seq9),   65'd0);
        checkOutput("abortDrop",  65'(drop9),  65'd0);
        sb9.delete();
        rx9.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        applyStimulus(0, 16'd0);
        checkOutput("hdrAfterRst", 65'(tdata9), 65'h0_A55A_0902_0000_0005);
        waitDrain(0, 50);

        // Periodic trigger, 100 enabled cycles
        for (int s = 0; s < 6; s++) begin
            fr = makeFrame(chA, 9, idA, 16'(s));
            foreach (fr[i]) sbA.push_back(fr[i]);
        end
        enA  = 1'b1;
        base = cyc;
        repeat (100) @(posedge clk);
        #1;
        enA = 1'b0;
        waitDrain(1, 50);
        checkOutput("autoFrames", 65'(startA.size()), 65'd6);
        for (int m = 0; m < 6; m++) begin
            checkOutput("autoStart", 65'(startA[m]), 65'(base + 16 * (m + 1)));
        end
        checkOutput("autoDrop", 65'(dropA), 65'd0);
        checkOutput("autoSeq", 65'(seqA), 65'd6);

        // Single-channel build
        applyStimulus(1, 16'd0);
        waitDrain(2, 20);
        checkOutput("oneCount", 65'(rx1.size()), 65'd3);
        checkOutput("oneHdr", rx1[0], 65'h0_A55A_0103_0000_0001);
        checkOutput("onePay", rx1[1], 65'h0_0000_0000_DEAD_BEEF);
        checkOutput("oneTrl", rx1[2], {1'b1, 32'hDEAD_BEEF, 16'h0000, 16'hE0F0});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
